riscvlong_core_scoreboard: RTL and testbench
============================================

# riscvlong_core_scoreboard

Hazard and bypass controller for the 7-stage long-pipeline RISCV core (D, X, M, X2, X3, W after fetch). It tracks in-flight register writes from X through W and selects the D-stage operand bypass source for rs1 and rs2. When an operand cannot yet be forwarded, it raises a decode hazard stall. It also carries the destination register to W to drive the regfile write port, and counts hazard stall cycles.

## Interface
- No parameters. The stage count is fixed at 5 tracked slots: X, M, X2, X3, W.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high reset.
- `inst_val_Dhl` in 1: valid instruction in D.
- `squash_Dhl` in 1: D instruction is killed this cycle (taken branch or jump redirect).
- `stall_back` in 1: backend hold (dmem or muldiv not ready). X..W slots freeze.
- `rs1_en_Dhl`, `rs2_en_Dhl` in 1 each: operand is read by the D instruction.
- `rs1_addr_Dhl`, `rs2_addr_Dhl` in 5 each: source register numbers.
- `rf_wen_Dhl` in 1: D instruction writes a register.
- `rd_addr_Dhl` in 5: destination register.
- `result_class_Dhl` in 2: result class. 0 = ALU, 1 = load, 2 = muldiv, 3 = reserved (treated as muldiv).
- `rs1_mux_sel_Dhl`, `rs2_mux_sel_Dhl` out 3 each: bypass source select. 0 = regfile, 1 = X, 2 = M, 3 = X2, 4 = X3, 5 = W.
- `stall_hazard_Dhl` out 1: hold F and D, and inject a bubble into X.
- `rf_wen_Whl` out 1: regfile write enable.
- `rf_waddr_Whl` out 5: regfile write address.
- `hazard_stall_count` out 32: number of cycles in which `stall_hazard_Dhl` was asserted and `stall_back` was low.

## Operation
- **Slot contents.** Each slot holds {val, rd[4:0], class[1:0]}.
- **Slot advance.** When `stall_back` = 0, the slots shift each cycle: W <= X3 <= X2 <= M <= X <= D-entry.
  - The D-entry is valid only when `inst_val_Dhl` & !`squash_Dhl` & !`stall_hazard_Dhl` & `rf_wen_Dhl` & (`rd_addr_Dhl` != 0).
  - Otherwise a bubble (val = 0) enters X.
- **Backend hold.** When `stall_back` = 1, all slots hold their values.
- **Readiness.** A slot's result is bypassable only if the class has produced it by that stage:
  - ALU: ready in X, M, X2, X3 and W.
  - Load: ready in M, X2, X3 and W.
  - Muldiv: ready in W only. The X3 bypass point carries the pre-muldiv value.
- **Operand match.** An operand matches a slot when the operand is enabled, its address is != 0, the slot is valid, and the slot's rd equals the address.
- **Source selection.** The youngest matching slot is chosen, with priority X > M > X2 > X3 > W.
  - If the youngest match is ready, sel = that slot's code.
  - If the youngest match is not ready, the operand is a hazard and sel is don't-care (drive 0).
  - If there is no match, sel = 0.
- **Stall.** `stall_hazard_Dhl` = `inst_val_Dhl` & !`squash_Dhl` & (rs1 hazard | rs2 hazard). Squash always overrides the stall.
- **Writeback.** `rf_wen_Whl` = W.val and `rf_waddr_Whl` = W.rd. Both are forced to 0 while `stall_back` = 1, so a held W slot does not write twice.
- **Counter.** `hazard_stall_count` increments by 1 in each counted cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- The sel outputs and the stall are combinational from the slot registers and the D inputs. There is no added latency.
- Slots and the counter update on the rising edge of `clk`.
- **Reset.** All slots become invalid and the counter becomes 0. While `reset` is high and on the cycle after it, the sels are 0, the stall is 0 and `rf_wen_Whl` is 0.
- **Reset mid-operation.** In-flight entries are discarded at that edge.
- **Stall resolution.** A stalled D instruction re-evaluates every cycle. It proceeds in the first cycle in which its youngest match is ready or has left W.
- **Latest resolution by class.** For a dependent instruction immediately behind the producer:
  - Load: 1 stall cycle, then sel = 2.
  - Muldiv: 4 stall cycles, then sel = 5.
  - ALU: 0 stall cycles, sel = 1.
- **Simultaneous events.**
  - With `stall_back` = 1 and a hazard, the stall is still asserted, but the counter does not count the cycle.
  - `squash_Dhl` together with a hazard gives stall 0 and a bubble into X.

## Configuration
- **`RISCVLONG_SCOREBOARD_BYPASS_EN` defined.** Full bypass behaviour as described above.
- **Undefined.**
  - Both sels are tied to 0.
  - Any operand match in X..W, ready or not, is a hazard.
  - The instruction stalls until the producer has left W, because the regfile is written at the end of the W cycle.
  - Dependent-instruction stalls become: ALU 5, load 5, muldiv 5 (the full X..W distance when immediately behind the producer).

## Test plan
- **ALU back-to-back.** `add x5` then `sub x6,x5,x7` -> rs1_sel = 1, rs2_sel = 0, stall 0. Under no-bypass: 5 stall cycles and count = 5.
- **Load-use.** `lw x3` then `add x4,x3,x3` -> 1 stall cycle, then rs1_sel = rs2_sel = 2. Counter = 1.
- **Muldiv-use.** `mul x8` then `add x9,x8,x0` -> 4 stall cycles, then rs1_sel = 5. rs2 is not enabled for x0, so rs2_sel = 0.
- **Youngest wins.** `addi x2` (now in X2), then `lw x2` (now in M), then `add x10,x2,x0` -> load is ready in M, so rs1_sel = 2, stall 0.
- **Squash and x0.**
  - `squash_Dhl` = 1 during a pending load-use hazard -> stall 0 and a bubble enters X.
  - A producer with rd = 0 followed by a read of x0 -> sel = 0, stall 0, and `rf_wen_Whl` never asserts.
- **Backend hold and reset.**
  - `stall_back` = 1 for 3 cycles with an ALU producer in W -> `rf_wen_Whl` = 0 during the hold, then asserts exactly once after release. The counter does not increment during the hold.
  - Reset mid-stream -> all sels are 0, the stall is 0 and the count is 0 on the next cycle.

Source files
------------

// File: rtl/riscvlong_core_scoreboard.sv
// riscvlong_core_scoreboard
// Hazard and bypass controller for the long-pipeline core. Tracks in-flight
// register writes in slots X, M, X2, X3, W, picks the D-stage bypass source
// for rs1/rs2, raises a decode hazard stall and drives the regfile write port.
//
// Ports:
//   clk, reset                       core clock, synchronous active-high reset
//   inst_val_Dhl, squash_Dhl         D instruction valid / killed this cycle
//   stall_back                       backend hold, slots freeze
//   rs{1,2}_en_Dhl, rs{1,2}_addr_Dhl D operand reads
//   rf_wen_Dhl, rd_addr_Dhl          D destination write
//   result_class_Dhl                 0 ALU, 1 load, 2/3 muldiv
//   rs{1,2}_mux_sel_Dhl              bypass select: 0 rf, 1 X, 2 M, 3 X2, 4 X3, 5 W
//   stall_hazard_Dhl                 hold F/D, bubble into X
//   rf_wen_Whl, rf_waddr_Whl         regfile write port
//   hazard_stall_count               cycles stalled on hazard outside backend hold
//
// Build option: define RISCVLONG_SCOREBOARD_BYPASS_EN for full bypassing.
// Without it, sels are 0 and any in-flight match stalls until the producer
// has left W.

module riscvlong_core_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_val_Dhl,
    input  logic        squash_Dhl,
    input  logic        stall_back,
    input  logic        rs1_en_Dhl,
    input  logic [4:0]  rs1_addr_Dhl,
    input  logic        rs2_en_Dhl,
    input  logic [4:0]  rs2_addr_Dhl,
    input  logic        rf_wen_Dhl,
    input  logic [4:0]  rd_addr_Dhl,
    input  logic [1:0]  result_class_Dhl,
    output logic [2:0]  rs1_mux_sel_Dhl,
    output logic [2:0]  rs2_mux_sel_Dhl,
    output logic        stall_hazard_Dhl,
    output logic        rf_wen_Whl,
    output logic [4:0]  rf_waddr_Whl,
    output logic [31:0] hazard_stall_count
);

    localparam int unsigned NUM_SLOTS = 5;
    localparam int unsigned SLOT_W    = NUM_SLOTS - 1;
    localparam int unsigned CNT_W     = 32;

    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic [1:0] cls;
    } slot_t;

    // Index 0 is X (youngest), index SLOT_W is W (oldest).
    slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
    logic  [CNT_W-1:0]     count_q, count_d;

    logic [3:0] op1_res, op2_res;
    logic       hazard;

`ifdef RISCVLONG_SCOREBOARD_BYPASS_EN
    // Whether a result of this class exists at the given slot position.
    function automatic logic slot_ready(input logic [1:0] cls, input int unsigned idx);
        logic rdy;
        case (cls)
            2'd0:    rdy = 1'b1;
            2'd1:    rdy = (idx >= 1);
            default: rdy = (idx == SLOT_W);
        endcase
        return rdy;
    endfunction
`endif

    // Youngest-match search for one operand; returns {hazard, sel}.
    function automatic logic [3:0] resolve_operand(
        input logic                  en,
        input logic [4:0]            addr,
        input slot_t [NUM_SLOTS-1:0] slots
    );
        logic       found;
        logic       haz;
        logic [2:0] sel;
        found = 1'b0;
        haz   = 1'b0;
        sel   = 3'd0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!found && en && (addr != 5'd0) && slots[i].val && (slots[i].rd == addr)) begin
                found = 1'b1;
`ifdef RISCVLONG_SCOREBOARD_BYPASS_EN
                if (slot_ready(slots[i].cls, i)) sel = 3'(i + 1);
                else                             haz = 1'b1;
`else
                haz = 1'b1;
`endif
            end
        end
        return {haz, sel};
    endfunction

    // Operand resolution and stall; outputs are quiet while reset is held.
    always_comb begin
        op1_res = resolve_operand(rs1_en_Dhl, rs1_addr_Dhl, slot_q);
        op2_res = resolve_operand(rs2_en_Dhl, rs2_addr_Dhl, slot_q);
        hazard  = inst_val_Dhl && !squash_Dhl && (op1_res[3] || op2_res[3]);

        stall_hazard_Dhl = hazard && !reset;
        rs1_mux_sel_Dhl  = reset ? 3'd0 : op1_res[2:0];
        rs2_mux_sel_Dhl  = reset ? 3'd0 : op2_res[2:0];
    end

    // Writeback port; suppressed during a backend hold so a held W writes once.
    always_comb begin
        rf_wen_Whl         = slot_q[SLOT_W].val && !stall_back && !reset;
        rf_waddr_Whl       = rf_wen_Whl ? slot_q[SLOT_W].rd : 5'd0;
        hazard_stall_count = count_q;
    end

    // Slot shift and stall counter next state.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (!stall_back) begin
            for (int unsigned i = 1; i < NUM_SLOTS; i++) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0].val = inst_val_Dhl && !squash_Dhl && !hazard && rf_wen_Dhl
                            && (rd_addr_Dhl != 5'd0);
            slot_d[0].rd  = rd_addr_Dhl;
            slot_d[0].cls = result_class_Dhl;
            if (hazard) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q  <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_riscvlong_core_scoreboard.sv
// Testbench for riscvlong_core_scoreboard: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against an
// in-flight instruction list model.

module tb_riscvlong_core_scoreboard;

`ifdef RISCVLONG_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_val, squash, stall_back;
    logic        rs1_en, rs2_en, rf_wen;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [1:0]  rclass;
    logic [2:0]  rs1_sel, rs2_sel;
    logic        stall_hz, wen_w;
    logic [4:0]  waddr_w;
    logic [31:0] hcount;

    always #5 clk = ~clk;

    riscvlong_core_scoreboard dut (
        .clk                (clk),
        .reset              (reset),
        .inst_val_Dhl       (inst_val),
        .squash_Dhl         (squash),
        .stall_back         (stall_back),
        .rs1_en_Dhl         (rs1_en),
        .rs1_addr_Dhl       (rs1_addr),
        .rs2_en_Dhl         (rs2_en),
        .rs2_addr_Dhl       (rs2_addr),
        .rf_wen_Dhl         (rf_wen),
        .rd_addr_Dhl        (rd_addr),
        .result_class_Dhl   (rclass),
        .rs1_mux_sel_Dhl    (rs1_sel),
        .rs2_mux_sel_Dhl    (rs2_sel),
        .stall_hazard_Dhl   (stall_hz),
        .rf_wen_Whl         (wen_w),
        .rf_waddr_Whl       (waddr_w),
        .hazard_stall_count (hcount)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: list of in-flight writers, youngest first; age 0 = X ... 4 = W.
    typedef struct {
        logic [4:0] rd;
        logic [1:0] cls;
        int         age;
    } ent_t;
    ent_t        q[$];
    int unsigned m_cnt = 0;
    bit          cnt_known = 1'b0;

    logic [2:0]  e_sel1, e_sel2, s_sel1, s_sel2;
    logic        e_stall, e_wen, s_stall, s_wen;
    logic [4:0]  e_waddr, s_waddr;
    logic [31:0] s_cnt;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endfunction

    function automatic bit ready(input logic [1:0] cls, input int age);
        if (cls == 2'd0) return 1'b1;
        if (cls == 2'd1) return age >= 1;
        return age == 4;
    endfunction

    function automatic void model_op(input logic en, input logic [4:0] a,
                                     output logic [2:0] sel, output logic haz);
        bit found;
        found = 1'b0;
        sel   = 3'd0;
        haz   = 1'b0;
        if (en && a != 5'd0) begin
            for (int k = 0; k < q.size(); k++) begin
                if (!found && q[k].rd == a) begin
                    found = 1'b1;
                    if (BYP && ready(q[k].cls, q[k].age)) sel = 3'(q[k].age + 1);
                    else                                  haz = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        logic h1, h2;
        model_op(rs1_en, rs1_addr, e_sel1, h1);
        model_op(rs2_en, rs2_addr, e_sel2, h2);
        e_stall = !reset && inst_val && !squash && (h1 || h2);
        if (reset) begin
            e_sel1 = 3'd0;
            e_sel2 = 3'd0;
        end
        e_wen   = 1'b0;
        e_waddr = 5'd0;
        if (!reset && !stall_back) begin
            foreach (q[k]) begin
                if (q[k].age == 4) begin
                    e_wen   = 1'b1;
                    e_waddr = q[k].rd;
                end
            end
        end
    endfunction

    function automatic void model_update();
        ent_t e;
        if (reset) begin
            q.delete();
            m_cnt     = 0;
            cnt_known = 1'b1;
        end else begin
            if (e_stall && !stall_back) m_cnt++;
            if (!stall_back) begin
                foreach (q[k]) q[k].age++;
                while (q.size() > 0 && q[q.size()-1].age > 4) void'(q.pop_back());
                if (inst_val && !squash && !e_stall && rf_wen && rd_addr != 5'd0) begin
                    e.rd  = rd_addr;
                    e.cls = rclass;
                    e.age = 0;
                    q.push_front(e);
                end
            end
        end
    endfunction

    // One clock: sample mid-cycle, compare against the model, advance the model at the edge.
    task automatic cycle();
        #4;
        s_sel1  = rs1_sel;
        s_sel2  = rs2_sel;
        s_stall = stall_hz;
        s_wen   = wen_w;
        s_waddr = waddr_w;
        s_cnt   = hcount;
        model_eval();
        check("rs1_sel", 32'(s_sel1), 32'(e_sel1));
        check("rs2_sel", 32'(s_sel2), 32'(e_sel2));
        check("stall", 32'(s_stall), 32'(e_stall));
        check("rf_wen", 32'(s_wen), 32'(e_wen));
        check("rf_waddr", 32'(s_waddr), 32'(e_waddr));
        if (cnt_known) check("count", s_cnt, 32'(m_cnt));
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        inst_val = 1'b0; squash = 1'b0; stall_back = 1'b0;
        rs1_en = 1'b0; rs2_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        rf_wen = 1'b0; rd_addr = 5'd0; rclass = 2'd0;
    endtask

    task automatic set_inst(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                            input logic w, input logic [4:0] rd, input logic [1:0] cls);
        set_idle();
        inst_val = 1'b1;
        rs1_en = e1; rs1_addr = a1; rs2_en = e2; rs2_addr = a2;
        rf_wen = w; rd_addr = rd; rclass = cls;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Hold the current D instruction until it stops stalling (bounded).
    task automatic wait_issue(output int stalls);
        stalls = 0;
        cycle();
        while (s_stall && stalls < 20) begin
            stalls++;
            cycle();
        end
        if (s_stall) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout cyc=%0d got=stall exp=issue", cyc);
        end
    endtask

    task automatic idle_pulses(input int n, output int pulses);
        set_idle();
        pulses = 0;
        repeat (n) begin
            cycle();
            pulses += int'(s_wen);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, p;
        set_idle();
        reset = 1'b1;

        // Reset state
        cycle();
        check("rst_stall", 32'(s_stall), 32'd0);
        check("rst_wen", 32'(s_wen), 32'd0);
        reset = 1'b0;
        cycle();
        check("rst_count", s_cnt, 32'd0);

        // ALU back-to-back: add x5; sub x6,x5,x7
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd0); cycle();
        set_inst(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 2'd0); wait_issue(st);
        check("alu_stalls", 32'(st), BYP ? 32'd0 : 32'd5);
        check("alu_rs1_sel", 32'(s_sel1), BYP ? 32'd1 : 32'd0);
        check("alu_rs2_sel", 32'(s_sel2), 32'd0);
        check("alu_count", s_cnt, BYP ? 32'd0 : 32'd5);

        // Load-use: lw x3; add x4,x3,x3
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd1); cycle();
        set_inst(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 2'd0); wait_issue(st);
        check("load_stalls", 32'(st), BYP ? 32'd1 : 32'd5);
        check("load_rs1_sel", 32'(s_sel1), BYP ? 32'd2 : 32'd0);
        check("load_rs2_sel", 32'(s_sel2), BYP ? 32'd2 : 32'd0);
        check("load_count", s_cnt, BYP ? 32'd1 : 32'd5);

        // Muldiv-use: mul x8; add x9,x8,x0
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd2); cycle();
        set_inst(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 2'd0); wait_issue(st);
        check("mul_stalls", 32'(st), BYP ? 32'd4 : 32'd5);
        check("mul_rs1_sel", 32'(s_sel1), BYP ? 32'd5 : 32'd0);
        check("mul_rs2_sel", 32'(s_sel2), 32'd0);

        // Youngest wins: addi x2; lw x2; bubble; add x10,x2,x0
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 2'd0); cycle();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 2'd1); cycle();
        set_idle(); cycle();
        set_inst(1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 5'd10, 2'd0); wait_issue(st);
        check("young_stalls", 32'(st), BYP ? 32'd0 : 32'd4);
        check("young_rs1_sel", 32'(s_sel1), BYP ? 32'd2 : 32'd0);

        // Squash during a load-use hazard: no stall, bubble enters X
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd1); cycle();
        set_inst(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 2'd0); squash = 1'b1; cycle();
        check("squash_stall", 32'(s_stall), 32'd0);
        idle_pulses(8, p);
        check("squash_writes", 32'(p), 32'd1);

        // rd = x0 producer then x0 read
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'd0); cycle();
        set_inst(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0); cycle();
        check("x0_rs1_sel", 32'(s_sel1), 32'd0);
        check("x0_stall", 32'(s_stall), 32'd0);
        idle_pulses(6, p);
        check("x0_writes", 32'(p), 32'd0);

        // Backend hold with an ALU producer in W
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd0); cycle();
        idle_pulses(4, p);
        check("hold_pre_writes", 32'(p), 32'd0);
        p = 0;
        stall_back = 1'b1;
        repeat (3) begin
            cycle();
            p += int'(s_wen);
        end
        check("hold_writes", 32'(p), 32'd0);
        idle_pulses(3, p);
        check("hold_post_writes", 32'(p), 32'd1);
        check("hold_waddr_cnt", s_cnt, 32'd0);

        // Hazard during backend hold: stall raised but not counted
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd1); cycle();
        set_inst(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd4, 2'd0); stall_back = 1'b1;
        cycle(); cycle();
        check("bh_stall", 32'(s_stall), 32'd1);
        check("bh_count", s_cnt, 32'd0);
        stall_back = 1'b0;
        cycle(); cycle();
        check("bh_count_after", s_cnt, 32'd1);
        check("bh_stall_after", 32'(s_stall), BYP ? 32'd0 : 32'd1);
        idle_pulses(6, p);

        // Reset mid-stream while a muldiv dependent is stalled
        do_reset();
        set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd2); cycle();
        set_inst(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 2'd0); cycle(); cycle();
        check("mid_count_pre", s_cnt, 32'd1);
        reset = 1'b1; cycle();
        check("mid_rst_stall", 32'(s_stall), 32'd0);
        reset = 1'b0; cycle();
        check("mid_stall", 32'(s_stall), 32'd0);
        check("mid_rs1_sel", 32'(s_sel1), 32'd0);
        check("mid_count", s_cnt, 32'd0);

        // Randomized traffic over a small register set to force collisions
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            stall_back = ($urandom_range(0, 5) == 0);
            inst_val   = ($urandom_range(0, 3) != 0);
            squash     = ($urandom_range(0, 7) == 0);
            rs1_en     = 1'($urandom_range(0, 1));
            rs2_en     = 1'($urandom_range(0, 1));
            rs1_addr   = 5'($urandom_range(0, 3));
            rs2_addr   = 5'($urandom_range(0, 3));
            rf_wen     = ($urandom_range(0, 3) != 0);
            rd_addr    = 5'($urandom_range(0, 3));
            rclass     = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
